pipeline_fifo: RTL

- Parametrised, multi-entry successor to the single-entry valid/ready pipeline stage.
- Buffers up to DEPTH words between two pipeline stages. Sustains one transfer per cycle in each direction.
- Registers in_ready, so there is no combinational path from out_ready to in_ready.
- Adds flush, occupancy count and almost-full indication. Used between IFU/IDU/EXU/LSU stages and in front of memory request queues.

---
 rtl/pipeline_fifo.sv | 93 +++++++++
 1 files changed

// File: rtl/pipeline_fifo.sv
// Multi-entry valid/ready buffer between pipeline stages, with flush, occupancy count and almost-full.
// Latency: a word pushed in cycle N is presented on out_data from cycle N+1; one transfer per cycle each way.
// Backpressure: in_ready is decoded from the count register only, so a pop while full re-opens input one cycle later.
module pipeline_fifo #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pipeline_flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // A non-power-of-two depth would break the free-running pointer wrap.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_cfg
            $error("pipeline_fifo: illegal DEPTH/AFULL_LEVEL configuration");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  wr_en;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & ~pipeline_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pipeline_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
